// File: rtl/bin2bcd_serial_pkg.sv
// bin2bcd_serial_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   - state_t : two-state controller encoding (IDLE / CONV)
//   - maxBcd  : constant function giving the largest value representable
//               in a given number of BCD digits (10^digits - 1)
package bin2bcd_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Usable in localparam expressions, so the overflow threshold tracks
  // the DIGITS parameter of whichever instance imports this package.
  function automatic int unsigned maxBcd(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < digits; k++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial_bcd_add3.sv
// bcd_add3
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
// Ports:
//   i_digit : 4-bit BCD digit before correction
//   o_digit : 4-bit corrected digit
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial
// Serial double-dabble binary-to-BCD converter, one bit per clock.
// A conversion takes BIN_W cycles after start is accepted; results and the
// overflow flag are held between completions.
// Parameters:
//   BIN_W  : binary input width (4..16)
//   DIGITS : number of BCD output digits (1..5)
//   SAT    : 1 = saturate to all nines on overflow, 0 = wrap mod 10^DIGITS
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request a conversion (ignored while busy)
//   bin_in   : unsigned binary value, sampled when start is accepted
//   busy     : conversion in progress
//   done     : one-cycle pulse when bcd_out/overflow are freshly updated
//   bcd_out  : packed BCD result, least significant digit in [3:0]
//   overflow : last converted value exceeded 10^DIGITS - 1
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2,
  parameter int SAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int                 CNT_W     = $clog2(BIN_W + 1);
  localparam int                 BCD_W     = 4 * DIGITS;
  localparam logic [31:0]        MAX_VAL   = 32'(maxBcd(DIGITS));
  localparam logic [BCD_W-1:0]   ALL_NINES = {DIGITS{4'h9}};
  localparam logic [CNT_W-1:0]   STEPS     = CNT_W'(BIN_W);

  state_t                    r_state;
  state_t                    w_nextState;
  logic [BIN_W-1:0]          r_bin;
  logic [BCD_W-1:0]          r_scratch;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_ovfNext;
  logic                      r_done;
  logic [BCD_W-1:0]          r_bcd;
  logic                      r_ovf;
  logic [BCD_W-1:0]          w_adj;
  logic [BCD_W+BIN_W-1:0]    w_shift;
  logic                      w_accept;
  logic                      w_lastStep;

  // One correction cell per digit; there is no cell above the top digit,
  // so whatever shifts out of it is dropped and the result wraps mod 10^DIGITS.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_shift    = {w_adj, r_bin} << 1;
  assign w_accept   = (r_state == IDLE) && start;
  assign w_lastStep = (r_state == CONV) && (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: leave CONV on the edge that performs the last step
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (start)      w_nextState = CONV;
      CONV:    if (w_lastStep) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift during CONV, publish on the last step.
  // Published outputs are only written on completion, so they stay frozen
  // for the whole conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovfNext <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin     <= bin_in;
        r_scratch <= '0;
        r_cnt     <= STEPS;
        r_ovfNext <= (32'(bin_in) > MAX_VAL);
      end else if (r_state == CONV) begin
        r_scratch <= w_shift[BIN_W +: BCD_W];
        r_bin     <= w_shift[BIN_W-1:0];
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_lastStep) begin
          r_done <= 1'b1;
          r_ovf  <= r_ovfNext;
          r_bcd  <= ((SAT != 0) && r_ovfNext) ? ALL_NINES : w_shift[BIN_W +: BCD_W];
        end
      end
    end
  end

  assign busy     = (r_state == CONV);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb_bin2bcd_serial
// Scoreboard bench for bin2bcd_serial. Three instances:
//   dutA : defaults (BIN_W=7, DIGITS=2, SAT=1)
//   dutB : BIN_W=7, DIGITS=2, SAT=0, sharing dutA's inputs
//   dutC : BIN_W=10, DIGITS=3, SAT=1, swept over every input value
// Stimulus pushes expected results (value, overflow, done cycle) into a
// per-instance queue; independent monitors pop and compare on each done.
module tb_bin2bcd_serial;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        startAB;
  logic [6:0]  binAB;
  logic        busyA, doneA, ovfA;
  logic [7:0]  bcdA;
  logic        busyB, doneB, ovfB;
  logic [7:0]  bcdB;
  logic        startC;
  logic [9:0]  binC;
  logic        busyC, doneC, ovfC;
  logic [11:0] bcdC;

  exp_t        qA[$];
  exp_t        qB[$];
  exp_t        qC[$];
  int          passCnt  = 0;
  int          totalCnt = 0;
  int          cycleCnt = 0;
  logic [7:0]  heldA    = '0;
  logic [7:0]  heldB    = '0;

  bin2bcd_serial #(.BIN_W(7), .DIGITS(2), .SAT(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startAB), .bin_in(binAB),
    .busy(busyA), .done(doneA), .bcd_out(bcdA), .overflow(ovfA)
  );

  bin2bcd_serial #(.BIN_W(7), .DIGITS(2), .SAT(0)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startAB), .bin_in(binAB),
    .busy(busyB), .done(doneB), .bcd_out(bcdB), .overflow(ovfB)
  );

  bin2bcd_serial #(.BIN_W(10), .DIGITS(3), .SAT(1)) dutC (
    .clk(clk), .rst_n(rst_n), .start(startC), .bin_in(binC),
    .busy(busyC), .done(doneC), .bcd_out(bcdC), .overflow(ovfC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: every done must match the oldest outstanding expectation,
  // including the cycle on which it appears.
  always @(negedge clk) begin : monA
    exp_t e;
    if (doneA === 1'b1) begin
      if (qA.size() == 0) checkOutput("A unexpected done", 1, 0);
      else begin
        e = qA.pop_front();
        checkOutput("A bcd", 32'(bcdA), 32'(e.bcd));
        checkOutput("A ovf", 32'(ovfA), 32'(e.ovf));
        checkOutput("A done cycle", cycleCnt, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (doneB === 1'b1) begin
      if (qB.size() == 0) checkOutput("B unexpected done", 1, 0);
      else begin
        e = qB.pop_front();
        checkOutput("B bcd", 32'(bcdB), 32'(e.bcd));
        checkOutput("B ovf", 32'(ovfB), 32'(e.ovf));
        checkOutput("B done cycle", cycleCnt, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : monC
    exp_t e;
    if (doneC === 1'b1) begin
      if (qC.size() == 0) checkOutput("C unexpected done", 1, 0);
      else begin
        e = qC.pop_front();
        checkOutput("C bcd", 32'(bcdC), 32'(e.bcd));
        checkOutput("C ovf", 32'(ovfC), 32'(e.ovf));
        checkOutput("C done cycle", cycleCnt, e.cyc);
      end
    end
  end

  // Called on a negedge; returns on the done-cycle negedge so the next call
  // exercises back-to-back acceptance. With spam set, start stays high with
  // a different value throughout the conversion.
  task automatic applyStimulus(input logic [6:0] v,
                               input logic [7:0] eA, input logic eOA,
                               input logic [7:0] eB, input logic eOB,
                               input bit spam, input logic [6:0] spamV);
    startAB = 1'b1;
    binAB   = v;
    qA.push_back('{bcd: 12'(eA), ovf: eOA, cyc: cycleCnt + 8});
    qB.push_back('{bcd: 12'(eB), ovf: eOB, cyc: cycleCnt + 8});
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 8) begin
        startAB = spam;
        if (spam) binAB = spamV;
        checkOutput("A busy during conv", 32'(busyA), 1);
        checkOutput("A bcd held during conv", 32'(bcdA), 32'(heldA));
        checkOutput("B bcd held during conv", 32'(bcdB), 32'(heldB));
      end else begin
        startAB = 1'b0;
        checkOutput("A busy on done cycle", 32'(busyA), 0);
      end
    end
    heldA = eA;
    heldB = eB;
  endtask

  task automatic applyC(input int v);
    int          m;
    logic [11:0] e;
    m = (v > 999) ? 999 : v;
    e = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    startC = 1'b1;
    binC   = 10'(v);
    qC.push_back('{bcd: e, ovf: (v > 999), cyc: cycleCnt + 11});
    @(negedge clk);
    startC = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    startAB = 1'b0;
    binAB   = '0;
    startC  = 1'b0;
    binC    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset A bcd", 32'(bcdA), 0);
    checkOutput("reset A ovf", 32'(ovfA), 0);
    checkOutput("reset A busy", 32'(busyA), 0);
    checkOutput("reset A done", 32'(doneA), 0);
    checkOutput("reset C bcd", 32'(bcdC), 0);
    checkOutput("reset C busy", 32'(busyC), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(7'd57,  8'h57, 1'b0, 8'h57, 1'b0, 1'b0, 7'd0);
    applyStimulus(7'd0,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 7'd0);
    applyStimulus(7'd99,  8'h99, 1'b0, 8'h99, 1'b0, 1'b0, 7'd0);
    applyStimulus(7'd10,  8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 7'd0);
    @(negedge clk);
    applyStimulus(7'd42,  8'h42, 1'b0, 8'h42, 1'b0, 1'b1, 7'd99);
    applyStimulus(7'd99,  8'h99, 1'b0, 8'h99, 1'b0, 1'b0, 7'd0);
    applyStimulus(7'd100, 8'h99, 1'b1, 8'h00, 1'b1, 1'b0, 7'd0);
    applyStimulus(7'd127, 8'h99, 1'b1, 8'h27, 1'b1, 1'b0, 7'd0);

    // Abort a conversion of 88 partway through with an async reset
    @(negedge clk);
    startAB = 1'b1;
    binAB   = 7'd88;
    @(negedge clk);
    startAB = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort A bcd", 32'(bcdA), 0);
    checkOutput("abort A ovf", 32'(ovfA), 0);
    checkOutput("abort A busy", 32'(busyA), 0);
    checkOutput("abort B bcd", 32'(bcdB), 0);
    checkOutput("abort B ovf", 32'(ovfB), 0);
    @(negedge clk);
    rst_n = 1'b1;
    heldA = '0;
    heldB = '0;
    repeat (12) @(negedge clk);
    checkOutput("post-abort A bcd", 32'(bcdA), 0);
    applyStimulus(7'd13,  8'h13, 1'b0, 8'h13, 1'b0, 1'b0, 7'd0);

    for (int v = 0; v < 1024; v++) applyC(v);

    repeat (3) @(negedge clk);
    checkOutput("A queue drained", qA.size(), 0);
    checkOutput("B queue drained", qB.size(), 0);
    checkOutput("C queue drained", qC.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
